// File: rtl/os_gf2_div.sv
// ============================================================================
// os_gf2_div : bit-serial GF(2) polynomial divider, 16-bit dividend / 8-bit divisor
// Revision   : 1.0
// ============================================================================
`default_nettype none

module os_gf2_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [6:0]  remainder,
    output logic        div_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] w_q;
    logic [15:0] q_q;
    logic [7:0]  d_q;
    logic [3:0]  i_q;
    logic [2:0]  deg_q;
    logic [15:0] quotient_q;
    logic [6:0]  remainder_q;
    logic        err_q;

    logic [2:0]  deg_d;
    logic [3:0]  shift_d;
    logic [15:0] w_d;
    logic [15:0] q_d;

    // Priority encoder: the highest set divisor bit wins.
    always_comb begin
        deg_d = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (divisor[k]) begin
                deg_d = 3'(k);
            end
        end
    end

    // One long-division step at coefficient i; i >= deg always holds in RUN.
    always_comb begin
        shift_d = i_q - {1'b0, deg_q};
        w_d     = w_q;
        q_d     = q_q;
        if (w_q[i_q]) begin
            w_d = w_q ^ ({8'h00, d_q} << shift_d);
            q_d = q_q | (16'h0001 << shift_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            w_q         <= 16'h0000;
            q_q         <= 16'h0000;
            d_q         <= 8'h00;
            i_q         <= 4'd0;
            deg_q       <= 3'd0;
            quotient_q  <= 16'h0000;
            remainder_q <= 7'h00;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_q   <= dividend;
                        d_q   <= divisor;
                        q_q   <= 16'h0000;
                        i_q   <= 4'd15;
                        deg_q <= deg_d;
                        if (divisor == 8'h00) begin
                            quotient_q  <= 16'h0000;
                            remainder_q <= 7'h00;
                            err_q       <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    w_q <= w_d;
                    q_q <= q_d;
                    if (i_q == {1'b0, deg_q}) begin
                        quotient_q  <= q_d;
                        remainder_q <= w_d[6:0];
                        err_q       <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        i_q <= i_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        quotient_q  <= 16'h0000;
                        remainder_q <= 7'h00;
                        err_q       <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_err   = err_q;

endmodule

`default_nettype wire
